// File: rtl/div_32_pkg.sv
// div_32_pkg: state encoding, default sizes and the wide negate helper shared by div_32 and the multiplier.
package div_32_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    localparam int NEG_W = 64;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2} div_state_e;
    // Callers zero-extend to NEG_W+1 bits and keep the low bits they need.
    function automatic logic [NEG_W:0] neg_w1(input logic [NEG_W:0] x);
        return ~x + {{NEG_W{1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/div_32_if.sv
// div_32_if: start/operand/result bundle between the execute stage and the divider.
// data_remainder exists only when DIV_REMAINDER_OUT_EN is defined.
interface div_32_if import div_32_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic data_exception;
    logic data_resultRDY;
    logic busy;
`ifdef DIV_REMAINDER_OUT_EN
    logic [WIDTH-1:0] data_remainder;
`endif
    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input data_result, data_exception, data_resultRDY, busy
`ifdef DIV_REMAINDER_OUT_EN
        , input data_remainder
`endif
    );
    modport slave (
        input ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
`ifdef DIV_REMAINDER_OUT_EN
        , output data_remainder
`endif
    );
endinterface

// File: rtl/div_32_step.sv
// div_32_step: one restoring-division iteration, combinational.
module div_32_step import div_32_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH:0]   div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    localparam int W1 = WIDTH + 1;
    logic [WIDTH:0] sh, nb, trial;
    logic c;
    // Subtract as sh + ~div + 1; a carry out of the top bit means the trial is non-negative.
    always_comb begin
        sh = W1'({rem_i, quo_i[WIDTH-1]});
        nb = ~div_i;
        trial = '0;
        c = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            trial[i] = sh[i] ^ nb[i] ^ c;
            c = (sh[i] & nb[i]) | ((sh[i] ^ nb[i]) & c);
        end
        rem_o = c ? trial : sh;
        quo_o = {quo_i[WIDTH-2:0], c};
    end
endmodule

// File: rtl/div_32.sv
// div_32: multicycle restoring signed divider, quotient truncated toward zero, fixed latency.
// Define DIV_REMAINDER_OUT_EN to expose the signed remainder on data_remainder.
module div_32 import div_32_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic clock,
    input logic reset,
    div_32_if.slave bus
);
    localparam int NW = NEG_W + 1;
    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] rem_q, rem_d, div_q, div_d, step_rem;
    logic [WIDTH-1:0] quo_q, quo_d, step_quo, res_q, res_d;
    logic sq_q, sq_d, dz_q, dz_d, exc_q, exc_d, rdy_q, rdy_d;
    logic start, last;
`ifdef DIV_REMAINDER_OUT_EN
    logic sr_q, sr_d;
    logic [WIDTH-1:0] remo_q, remo_d;
`endif
    assign start = bus.ctrl_DIV;
    assign last = cnt_q == CNT_W'(WIDTH - 1);

    div_32_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q), .quo_i(quo_q), .div_i(div_q), .rem_o(step_rem), .quo_o(step_quo)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // A start pulse aborts whatever is in flight, including the FIX edge.
    always_comb begin
        state_d = start ? ST_RUN : (state_q == ST_RUN) ? (last ? ST_FIX : ST_RUN) : ST_IDLE;
    end

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        sq_d = sq_q;
        dz_d = dz_q;
        res_d = res_q;
        exc_d = exc_q;
        rdy_d = state_q == ST_FIX && !start;
`ifdef DIV_REMAINDER_OUT_EN
        sr_d = sr_q;
        remo_d = remo_q;
`endif
        if (start) begin
            cnt_d = '0;
            rem_d = '0;
            quo_d = bus.data_operandA[WIDTH-1] ? WIDTH'(neg_w1(NW'(bus.data_operandA))) : bus.data_operandA;
            div_d = {1'b0, bus.data_operandB[WIDTH-1] ? WIDTH'(neg_w1(NW'(bus.data_operandB))) : bus.data_operandB};
            sq_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_d = bus.data_operandB == '0;
`ifdef DIV_REMAINDER_OUT_EN
            sr_d = bus.data_operandA[WIDTH-1];
`endif
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
            rem_d = step_rem;
            quo_d = step_quo;
        end else if (state_q == ST_FIX) begin
            res_d = dz_q ? '0 : sq_q ? WIDTH'(neg_w1(NW'(quo_q))) : quo_q;
            exc_d = dz_q;
`ifdef DIV_REMAINDER_OUT_EN
            remo_d = dz_q ? '0 : sr_q ? WIDTH'(neg_w1(NW'(rem_q))) : WIDTH'(rem_q);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            sq_q <= 1'b0;
            dz_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
            rdy_q <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
            sr_q <= 1'b0;
            remo_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
            sq_q <= sq_d;
            dz_q <= dz_d;
            res_q <= res_d;
            exc_q <= exc_d;
            rdy_q <= rdy_d;
`ifdef DIV_REMAINDER_OUT_EN
            sr_q <= sr_d;
            remo_q <= remo_d;
`endif
        end
    end

    always_comb begin
        bus.busy = state_q != ST_IDLE;
        bus.data_result = res_q;
        bus.data_exception = exc_q;
        bus.data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_OUT_EN
        bus.data_remainder = remo_q;
`endif
    end
endmodule

// File: tb/tb_div_32.sv
// tb_div_32: directed and random signed divisions checked against plain 64-bit arithmetic.
module tb_div_32;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] last_res;
    logic saw;
    logic [31:0] ra, rb;

    div_32_if #(.WIDTH(32)) bus();
    div_32 #(.WIDTH(32), .CNT_W(6)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return (b == 32'd0) ? 32'd0 : 32'(sa / sb);
    endfunction

    function automatic logic [31:0] mr(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return (b == 32'd0) ? 32'd0 : 32'(sa % sb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_result"}, bus.data_result, 32'd0);
        chk({tag, "_exception"}, 32'(bus.data_exception), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef DIV_REMAINDER_OUT_EN
        chk({tag, "_remainder"}, bus.data_remainder, 32'd0);
`endif
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clk);
        bus.ctrl_DIV = 1'b0;
    endtask

    // Entered at the first negedge after the sampling edge; the pulse is due 33 edges later.
    task automatic finish_op(input logic [31:0] a, input logic [31:0] b);
        int cyc = 0;
        int bc;
        bc = int'(bus.busy);
        while (!bus.data_resultRDY && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!bus.data_resultRDY) bc += int'(bus.busy);
        end
        chk("latency", 32'(cyc), 32'd33);
        chk("busy_cycles", 32'(bc), 32'd33);
        chk("result", bus.data_result, mq(a, b));
        chk("exception", 32'(bus.data_exception), 32'(b == 32'd0));
`ifdef DIV_REMAINDER_OUT_EN
        chk("remainder", bus.data_remainder, mr(a, b));
`endif
        @(negedge clk);
        chk("rdy_single", 32'(bus.data_resultRDY), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("result_hold", bus.data_result, mq(a, b));
        last_res = mq(a, b);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        start(a, b);
        finish_op(a, b);
    endtask

    initial begin
        rst = 1'b1;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post_reset");

        run(32'd7, 32'd2);
        run(32'hFFFF_FFF9, 32'd2);
        run(32'd5, 32'd0);
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'h8000_0000, 32'd1);
        run(32'h7FFF_FFFF, 32'h8000_0000);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 20);
            if (i % 4 == 1) rb = -rb;
            if (i == 15) rb = 32'd0;
            run(ra, rb);
        end

        // Restart 10 cycles into 100/7 with 9/3: only the second result may appear.
        start(32'd100, 32'd7);
        saw = 1'b0;
        repeat (9) begin
            @(negedge clk);
            saw |= bus.data_resultRDY;
        end
        start(32'd9, 32'd3);
        finish_op(32'd9, 32'd3);
        chk("abort_no_pulse", 32'(saw), 32'd0);

        // Start arriving on the FIX edge suppresses that result entirely.
        start(32'd100, 32'd7);
        repeat (32) @(negedge clk);
        chk("fix_state_busy", 32'(bus.busy), 32'd1);
        start(32'd50, 32'hFFFF_FFFA);
        chk("fix_abort_rdy", 32'(bus.data_resultRDY), 32'd0);
        chk("fix_abort_hold", bus.data_result, last_res);
        finish_op(32'd50, 32'hFFFF_FFFA);

        // Level-high start: the last sampled operands win.
        for (int k = 0; k < 5; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            bus.ctrl_DIV = 1'b1;
            bus.data_operandA = ra;
            bus.data_operandB = rb;
            @(negedge clk);
            chk("level_rdy", 32'(bus.data_resultRDY), 32'd0);
        end
        bus.ctrl_DIV = 1'b0;
        finish_op(ra, rb);

        // Reset at edge 20 of 100/7.
        start(32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("mid_reset");
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw |= bus.data_resultRDY;
        end
        chk("mid_reset_no_pulse", 32'(saw), 32'd0);

        // Reset together with a start still leaves the divider idle.
        start(32'd77, 32'd5);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.ctrl_DIV = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ctrl_DIV = 1'b0;
        chk_zero("reset_start");
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw |= bus.data_resultRDY;
        end
        chk("reset_start_no_pulse", 32'(saw), 32'd0);
        run(32'd100, 32'd7);
        chk("after_reset_14", last_res, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
